// File: rtl/dispensador_pkg.sv
// rtl/dispensador_pkg.sv - state encoding, item indices and request priority for the dispenser
package dispensador_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LIBERA   = 2'd1,
        RETIRADA = 2'd2,
        ERRO     = 2'd3
    } estado_t;

    localparam int PIZZA   = 3;
    localparam int BURGUER = 2;
    localparam int TORTA   = 1;
    localparam int SODA    = 0;

    // One-hot select of the highest-priority request; lower ones are dropped.
    function automatic logic [3:0] prioridade(input logic [3:0] req);
        logic [3:0] sel;
        sel = 4'b0000;
        if (req[PIZZA])
            sel[PIZZA] = 1'b1;
        else if (req[BURGUER])
            sel[BURGUER] = 1'b1;
        else if (req[TORTA])
            sel[TORTA] = 1'b1;
        else if (req[SODA])
            sel[SODA] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/sincronizador.sv
// rtl/sincronizador.sv - two-flop synchronizer with asynchronous active-high reset to 0
module sincronizador (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dispensador.sv
// rtl/dispensador.sv - product dispenser FSM with motor timeout; DISPENSADOR_ESTOQUE_EN adds per-item stock
module dispensador
    import dispensador_pkg::*;
#(
    parameter int T_MOTOR     = 25_000_000,
    parameter int CNT_W       = 26,
    parameter int ESTOQUE_INI = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pizza,
    input  logic       burguer,
    input  logic       torta,
    input  logic       soda,
    input  logic       sensor_saida,
    output logic [3:0] motor,
    output logic       ocupado,
    output logic       entregue,
    output logic       erro,
    output logic [3:0] esgotado
);

    estado_t          estado;
    logic             sens;
    logic [CNT_W-1:0] timer;
    logic [3:0]       pedido;

    sincronizador u_sincronizador (
        .clock (clock),
        .reset (reset),
        .d     (sensor_saida),
        .q     (sens)
    );

    assign pedido = {pizza, burguer, torta, soda} & ~esgotado;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= IDLE;
            motor    <= 4'b0000;
            ocupado  <= 1'b0;
            entregue <= 1'b0;
            erro     <= 1'b0;
            timer    <= '0;
        end else begin
            entregue <= 1'b0;
            case (estado)
                IDLE: begin
                    if (!sens && (pedido != 4'b0000)) begin
                        estado  <= LIBERA;
                        motor   <= prioridade(pedido);
                        ocupado <= 1'b1;
                        timer   <= CNT_W'(T_MOTOR);
                    end
                end
                LIBERA: begin
                    // Timer holds the motor-on cycles still allowed, counting the current one.
                    if (sens) begin
                        estado <= RETIRADA;
                        motor  <= 4'b0000;
                    end else if (timer <= CNT_W'(1)) begin
                        estado <= ERRO;
                        motor  <= 4'b0000;
                        erro   <= 1'b1;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
                RETIRADA: begin
                    if (!sens) begin
                        estado   <= IDLE;
                        ocupado  <= 1'b0;
                        entregue <= 1'b1;
                    end
                end
                ERRO: begin
                    motor   <= 4'b0000;
                    ocupado <= 1'b1;
                    erro    <= 1'b1;
                end
                default: begin
                    estado <= IDLE;
                    motor  <= 4'b0000;
                end
            endcase
        end
    end

`ifdef DISPENSADOR_ESTOQUE_EN
    localparam int EST_W = (ESTOQUE_INI < 2) ? 1 : $clog2(ESTOQUE_INI + 1);

    logic [EST_W-1:0] estoque [4];
    logic             retirou;

    assign retirou = (estado == LIBERA) && sens;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++)
                estoque[i] <= EST_W'(ESTOQUE_INI);
        end else if (retirou) begin
            for (int i = 0; i < 4; i++)
                if (motor[i] && (estoque[i] != '0))
                    estoque[i] <= estoque[i] - EST_W'(1);
        end
    end

    always_comb begin
        esgotado = 4'b0000;
        for (int i = 0; i < 4; i++)
            esgotado[i] = (estoque[i] == '0);
    end
`else
    // Without counters nothing can run out; a negative initial stock is not meaningful.
    assign esgotado = {4{ESTOQUE_INI < 0}};
`endif

endmodule

// File: tb/tb_dispensador.sv
// tb/tb_dispensador.sv - randomized self-checking bench for dispensador against a transaction-level model
`timescale 1ns/1ps
module tb_dispensador;

    localparam int T_MOTOR     = 20;
    localparam int ESTOQUE_INI = 2;
`ifdef DISPENSADOR_ESTOQUE_EN
    localparam bit COM_ESTOQUE = 1'b1;
`else
    localparam bit COM_ESTOQUE = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pizza = 1'b0, burguer = 1'b0, torta = 1'b0, soda = 1'b0;
    logic       sensor_saida = 1'b0;
    logic [3:0] motor, esgotado;
    logic       ocupado, entregue, erro;

    int total = 0;
    int bad   = 0;
    int stock [4];

    dispensador #(
        .T_MOTOR     (T_MOTOR),
        .CNT_W       (8),
        .ESTOQUE_INI (ESTOQUE_INI)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .pizza        (pizza),
        .burguer      (burguer),
        .torta        (torta),
        .soda         (soda),
        .sensor_saida (sensor_saida),
        .motor        (motor),
        .ocupado      (ocupado),
        .entregue     (entregue),
        .erro         (erro),
        .esgotado     (esgotado)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] r);
        {pizza, burguer, torta, soda} = r;
    endtask

    // Item served: the highest-indexed request whose stock is not exhausted.
    function automatic logic [3:0] model_pick(input logic [3:0] r);
        for (int i = 3; i >= 0; i--)
            if (r[i] && (!COM_ESTOQUE || stock[i] > 0))
                return 4'(1 << i);
        return 4'b0000;
    endfunction

    function automatic logic [3:0] model_esg();
        logic [3:0] e;
        for (int i = 0; i < 4; i++)
            e[i] = COM_ESTOQUE && (stock[i] == 0);
        return e;
    endfunction

    task automatic model_deliver(input logic [3:0] win);
        for (int i = 0; i < 4; i++)
            if (win[i] && stock[i] > 0)
                stock[i]--;
    endtask

    task automatic apply_reset;
        drive_req(4'b0000);
        sensor_saida = 1'b0;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            stock[i] = ESTOQUE_INI;
    endtask

    // One request transaction: sensor rises after d motor cycles, is held h cycles, then cleared.
    task automatic dispense_and_check(input string nome, input logic [3:0] r, input logic [3:0] mid,
                                      input int d, input int h);
        logic [3:0] win, mot_seen, post_mot, esg_exp;
        int         mot_cycles, ent_tick, ent_count;
        bit         multi, busy_ok;
        win = model_pick(r);
        mot_cycles = 0; ent_tick = 0; ent_count = 0; multi = 0; busy_ok = 1;
        drive_req(r);
        tick;
        drive_req(4'b0000);
        mot_seen = motor;
        if (motor == 4'b0000) begin
            repeat (4) begin
                tick;
                if (motor != 4'b0000 || ocupado) busy_ok = 0;
            end
        end else begin
            for (int c = 1; c <= 40; c++) begin
                if (motor != 4'b0000) mot_cycles++;
                if ($countones(motor) > 1) multi = 1;
                if (!ocupado) busy_ok = 0;
                if (c == d) sensor_saida = 1'b1;
                if (c == 2) drive_req(mid);
                else if (c == 3) drive_req(4'b0000);
                if (motor == 4'b0000) break;
                tick;
            end
            drive_req(4'b0000);
            repeat (h) begin
                tick;
                if (entregue || !ocupado || motor != 4'b0000) busy_ok = 0;
            end
            sensor_saida = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                tick;
                if (entregue) begin
                    ent_count++;
                    if (ent_tick == 0) ent_tick = k;
                    if (ocupado) busy_ok = 0;
                end else if (ent_tick == 0 && !ocupado) begin
                    busy_ok = 0;
                end
            end
        end
        post_mot = motor;
        if (win != 4'b0000) model_deliver(win);
        esg_exp = model_esg();

        total++;
        if (mot_seen !== win) begin
            bad++; $display("FAIL %s motor: got %b want %b", nome, mot_seen, win);
        end
        total++;
        if (mot_cycles != ((win != 0) ? d + 2 : 0)) begin
            bad++; $display("FAIL %s motor_cycles: got %0d want %0d", nome, mot_cycles, (win != 0) ? d + 2 : 0);
        end
        total++;
        if (ent_tick != ((win != 0) ? 3 : 0)) begin
            bad++; $display("FAIL %s entregue_latency: got %0d want %0d", nome, ent_tick, (win != 0) ? 3 : 0);
        end
        total++;
        if (ent_count != ((win != 0) ? 1 : 0)) begin
            bad++; $display("FAIL %s entregue_count: got %0d want %0d", nome, ent_count, (win != 0) ? 1 : 0);
        end
        total++;
        if (multi !== 1'b0) begin
            bad++; $display("FAIL %s motor_onehot: got multi=%0d want 0", nome, multi);
        end
        total++;
        if (busy_ok !== 1'b1) begin
            bad++; $display("FAIL %s ocupado_profile: got ok=%0d want 1", nome, busy_ok);
        end
        total++;
        if (post_mot !== 4'b0000) begin
            bad++; $display("FAIL %s motor_after: got %b want 0000", nome, post_mot);
        end
        total++;
        if (esgotado !== esg_exp) begin
            bad++; $display("FAIL %s esgotado: got %b want %b", nome, esgotado, esg_exp);
        end
    endtask

    task automatic test_reset;
        apply_reset;
        total++; if (motor !== 4'b0000) begin bad++; $display("FAIL reset motor: got %b want 0000", motor); end
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL reset ocupado: got %b want 0", ocupado); end
        total++; if (entregue !== 1'b0) begin bad++; $display("FAIL reset entregue: got %b want 0", entregue); end
        total++; if (erro !== 1'b0) begin bad++; $display("FAIL reset erro: got %b want 0", erro); end
        total++; if (esgotado !== model_esg()) begin bad++; $display("FAIL reset esgotado: got %b want %b", esgotado, model_esg()); end
    endtask

    task automatic test_entrega;
        dispense_and_check("entrega_burguer", 4'b0100, 4'b0000, 5, 10);
    endtask

    task automatic test_prioridade;
        dispense_and_check("prioridade", 4'b1001, 4'b0010, 4, 3);
    endtask

    task automatic test_travamento;
        logic [3:0] first;
        int         cyc;
        bit         early_erro;
        cyc = 0; early_erro = 0;
        drive_req(4'b0001);
        tick;
        drive_req(4'b0000);
        first = motor;
        for (int c = 1; c <= 40; c++) begin
            if (motor == 4'b0000) break;
            cyc++;
            if (erro) early_erro = 1;
            tick;
        end
        total++; if (first !== 4'b0001) begin bad++; $display("FAIL jam motor: got %b want 0001", first); end
        total++; if (cyc != T_MOTOR) begin bad++; $display("FAIL jam motor_cycles: got %0d want %0d", cyc, T_MOTOR); end
        total++; if (early_erro !== 1'b0) begin bad++; $display("FAIL jam erro_early: got %0d want 0", early_erro); end
        total++; if (erro !== 1'b1) begin bad++; $display("FAIL jam erro: got %b want 1", erro); end
        drive_req(4'b1000);
        tick;
        drive_req(4'b0000);
        repeat (4) tick;
        total++; if (motor !== 4'b0000) begin bad++; $display("FAIL jam ignore motor: got %b want 0000", motor); end
        total++; if ({ocupado, erro} !== 2'b11) begin bad++; $display("FAIL jam held: got ocupado,erro=%b want 11", {ocupado, erro}); end
        #2 reset = 1'b1;
        #1;
        total++; if ({motor, ocupado, erro, entregue} !== 7'b0) begin
            bad++; $display("FAIL jam reset_clear: got motor=%b ocupado=%b erro=%b entregue=%b want all 0", motor, ocupado, erro, entregue);
        end
        tick;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) stock[i] = ESTOQUE_INI;
    endtask

    task automatic test_bloqueio;
        bit quiet;
        quiet = 1;
        sensor_saida = 1'b1;
        repeat (3) tick;
        drive_req(4'b1000);
        tick;
        drive_req(4'b0000);
        repeat (5) begin
            if (motor != 4'b0000 || ocupado) quiet = 0;
            tick;
        end
        total++; if (quiet !== 1'b1) begin bad++; $display("FAIL bloqueio: got quiet=%0d want 1", quiet); end
        sensor_saida = 1'b0;
        repeat (4) tick;
        total++; if ({motor, ocupado, entregue} !== 6'b0) begin
            bad++; $display("FAIL bloqueio after: got motor=%b ocupado=%b entregue=%b want 0", motor, ocupado, entregue);
        end
    endtask

    task automatic test_estoque;
        apply_reset;
        for (int n = 1; n <= 3; n++)
            dispense_and_check($sformatf("estoque_torta%0d", n), 4'b0010, 4'b0000,
                               int'($urandom_range(1, 15)), int'($urandom_range(1, 8)));
        total++;
        if (esgotado !== (COM_ESTOQUE ? 4'b0010 : 4'b0000)) begin
            bad++; $display("FAIL estoque final: got %b want %b", esgotado, COM_ESTOQUE ? 4'b0010 : 4'b0000);
        end
    endtask

    task automatic test_reset_meio;
        bit no_pulse;
        no_pulse = 1;
        drive_req(4'b0100);
        tick;
        drive_req(4'b0000);
        repeat (3) tick;
        total++; if (motor !== 4'b0100) begin bad++; $display("FAIL reset_meio pre: got %b want 0100", motor); end
        #2 reset = 1'b1;
        #1;
        total++; if ({motor, ocupado} !== 5'b0) begin
            bad++; $display("FAIL reset_meio async: got motor=%b ocupado=%b want 0", motor, ocupado);
        end
        tick;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) stock[i] = ESTOQUE_INI;
        repeat (6) begin
            if (entregue || motor != 4'b0000) no_pulse = 0;
            tick;
        end
        total++; if (no_pulse !== 1'b1) begin bad++; $display("FAIL reset_meio entregue: got clean=%0d want 1", no_pulse); end
    endtask

    task automatic test_aleatorio;
        apply_reset;
        for (int n = 0; n < 10; n++)
            dispense_and_check($sformatf("aleatorio%0d", n), 4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                               int'($urandom_range(1, 15)), int'($urandom_range(1, 8)));
    endtask

    initial begin
        test_reset;
        test_entrega;
        test_prioridade;
        test_travamento;
        test_bloqueio;
        test_estoque;
        test_reset_meio;
        test_aleatorio;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
